// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (DIFF = A - B - BIN), LSB first, one full-subtractor cell.
// Optional two's-complement overflow output OVF when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           state, state_nxt;
   logic             load, last;
   logic [WIDTH-1:0] sa, sb;
   logic [WIDTH-2:0] res;
   logic [CW-1:0]    cnt;
   logic             br;
   logic [1:0]       fs;
   logic             d_bit, br_nxt;
   logic [WIDTH-1:0] res_full;
`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb, b_msb;
`endif

   // returns {borrow_out, difference} of one full-subtractor cell
   function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
      return {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
   endfunction

   assign fs       = full_sub(sa[0], sb[0], br);
   assign d_bit    = fs[0];
   assign br_nxt   = fs[1];
   assign res_full = {d_bit, res};
   assign busy     = (state == S_RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      last      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RUN;
               load      = 1'b1;
            end
         end
         S_RUN: begin
            if (cnt == LAST) begin
               state_nxt = S_IDLE;
               last      = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // serial datapath; result bits enter at the top so the LSB lands at bit 0 after WIDTH steps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa   <= '0;
         sb   <= '0;
         res  <= '0;
         cnt  <= '0;
         br   <= 1'b0;
         done <= 1'b0;
         diff <= '0;
         bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
`endif
      end else begin
         done <= last;
         if (load) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
         end else if (state == S_RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            br  <= br_nxt;
            res <= res_full[WIDTH-1:1];
            if (!last) cnt <= cnt + 1'b1;
         end
         // outputs change only on completion so partial results never show
         if (last) begin
            diff <= res_full;
            bout <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= (a_msb != b_msb) & (d_bit != a_msb);
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) against an integer-arithmetic model.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         bin = 1'b0;
   logic         busy, done, bout;
   logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int total = 0;
   int bad   = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
      , .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   // {bout, diff}: low W+1 bits of the true integer difference
   function automatic logic [W:0] ref_sub(input int av, input int bv, input int bi);
      int r;
      r = av - bv - bi;
      return r[W:0];
   endfunction

   // signed overflow: true signed result outside the W-bit range
   function automatic logic ref_ovf(input int av, input int bv, input int bi);
      int sa, sb, sr;
      sa = (av >= 2**(W-1)) ? av - 2**W : av;
      sb = (bv >= 2**(W-1)) ? bv - 2**W : bv;
      sr = sa - sb - bi;
      return (sr < -(2**(W-1))) || (sr > 2**(W-1) - 1);
   endfunction

   // one operation; inputs are scrambled during RUN, busy checked each RUN cycle
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                         output logic [W-1:0] gd, output logic gb, output logic go,
                         output int lat);
      @(negedge clk);
      a = av; b = bv; bin = bi; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         if (!busy) begin
            total++;
            bad++;
            $display("FAIL busy_run: busy=%0b cycle=%0d required busy=1", busy, i);
         end
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      gd = diff;
      gb = bout;
`ifdef SERIAL_SUB_OVF_EN
      go = ovf;
`else
      go = 1'b0;
`endif
      total++;
      if (lat !== W) begin
         bad++;
         $display("FAIL latency: got=%0d required=%0d", lat, W);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_done: busy=%0b required=0", busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy, done, bout, diff} !== '0) begin
         bad++;
         $display("FAIL reset: busy=%0b done=%0b bout=%0b diff=%h required all 0", busy, done, bout, diff);
      end
`ifdef SERIAL_SUB_OVF_EN
      total++;
      if (ovf !== 1'b0) begin
         bad++;
         $display("FAIL reset_ovf: ovf=%0b required=0", ovf);
      end
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [W-1:0] gd; logic gb, go; int lat;
      logic [W-1:0] ta [3] = '{4'd9, 4'd3, 4'd0};
      logic [W-1:0] tb [3] = '{4'd3, 4'd9, 4'd0};
      logic         tc [3] = '{1'b0, 1'b0, 1'b1};
      logic [W:0]   ex [3] = '{5'h06, 5'h1A, 5'h1F};
      for (int k = 0; k < 3; k++) begin
         run_op(ta[k], tb[k], tc[k], gd, gb, go, lat);
         total++;
         if ({gb, gd} !== ex[k]) begin
            bad++;
            $display("FAIL basic%0d: bout,diff=%h required=%h", k, {gb, gd}, ex[k]);
         end
         @(posedge clk);
         #1;
         total++;
         if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse%0d: done=%0b required=0", k, done);
         end
      end
   endtask

   task automatic test_sweep();
      logic [W-1:0] gd; logic gb, go; int lat; logic [W:0] ex;
      for (int av = 0; av < 2**W; av++)
         for (int bv = 0; bv < 2**W; bv++)
            for (int bi = 0; bi < 2; bi++) begin
               run_op(W'(av), W'(bv), 1'(bi), gd, gb, go, lat);
               ex = ref_sub(av, bv, bi);
               total++;
               if ({gb, gd} !== ex) begin
                  bad++;
                  $display("FAIL sweep a=%0d b=%0d bin=%0d: bout,diff=%h required=%h", av, bv, bi, {gb, gd}, ex);
               end
`ifdef SERIAL_SUB_OVF_EN
               total++;
               if (go !== ref_ovf(av, bv, bi)) begin
                  bad++;
                  $display("FAIL sweep_ovf a=%0d b=%0d bin=%0d: ovf=%0b required=%0b", av, bv, bi, go, ref_ovf(av, bv, bi));
               end
`endif
            end
   endtask

   task automatic test_back_to_back();
      int hits [$];
      @(negedge clk);
      a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            hits.push_back(i);
            total++;
            if ({bout, diff} !== 5'h03) begin
               bad++;
               $display("FAIL held_diff: bout,diff=%h required=03", {bout, diff});
            end
         end
      end
      start = 1'b0;
      total++;
      if (hits.size() < 3 || hits[0] != W) begin
         bad++;
         $display("FAIL held_first: dones=%0d first=%0d required first=%0d", hits.size(),
                  (hits.size() > 0) ? hits[0] : -1, W);
      end
      for (int k = 1; k < hits.size(); k++) begin
         total++;
         if (hits[k] - hits[k-1] != W + 1) begin
            bad++;
            $display("FAIL held_spacing: got=%0d required=%0d", hits[k] - hits[k-1], W + 1);
         end
      end
      repeat (W + 2) @(posedge clk);
   endtask

   task automatic test_ignore_busy();
      int ndone = 0;
      @(negedge clk);
      a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         if (i == 2) begin
            a = 4'd1; b = 4'd0; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (i < W) begin
            total++;
            if (diff !== 4'd3) begin
               bad++;
               $display("FAIL hold_diff: diff=%h required=3", diff);
            end
         end
         if (done) begin
            ndone++;
            total++;
            if ({bout, diff} !== 5'h06) begin
               bad++;
               $display("FAIL ignore_diff: bout,diff=%h required=06", {bout, diff});
            end
         end
      end
      start = 1'b0;
      total++;
      if (ndone != 1) begin
         bad++;
         $display("FAIL ignore_count: dones=%0d required=1", ndone);
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] gd; logic gb, go; int lat; int ndone = 0;
      @(negedge clk);
      a = 4'd7; b = 4'd1; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      total++;
      if ({busy, done, bout, diff} !== '0) begin
         bad++;
         $display("FAIL mid_reset: busy=%0b done=%0b bout=%0b diff=%h required all 0", busy, done, bout, diff);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) ndone++;
      end
      total++;
      if (ndone != 0) begin
         bad++;
         $display("FAIL mid_reset_quiet: active cycles=%0d required=0", ndone);
      end
      run_op(4'd7, 4'd1, 1'b0, gd, gb, go, lat);
      total++;
      if ({gb, gd} !== 5'h06) begin
         bad++;
         $display("FAIL after_reset: bout,diff=%h required=06", {gb, gd});
      end
   endtask

   task automatic test_ovf();
      logic [W-1:0] gd; logic gb, go; int lat;
      run_op(4'd8, 4'd1, 1'b0, gd, gb, go, lat);
      total++;
      if ({gb, gd} !== ref_sub(8, 1, 0)) begin
         bad++;
         $display("FAIL ovf_case1: bout,diff=%h required=%h", {gb, gd}, ref_sub(8, 1, 0));
      end
`ifdef SERIAL_SUB_OVF_EN
      total++;
      if (go !== 1'b1) begin
         bad++;
         $display("FAIL ovf_set: ovf=%0b required=1", go);
      end
`endif
      run_op(4'd6, 4'd2, 1'b0, gd, gb, go, lat);
      total++;
      if ({gb, gd} !== 5'h04) begin
         bad++;
         $display("FAIL ovf_case2: bout,diff=%h required=04", {gb, gd});
      end
`ifdef SERIAL_SUB_OVF_EN
      total++;
      if (go !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clear: ovf=%0b required=0", go);
      end
`endif
   endtask

   task automatic test_random();
      logic [W-1:0] gd; logic gb, go; int lat; int av, bv, bi;
      for (int k = 0; k < 40; k++) begin
         av = int'($urandom_range(2**W - 1));
         bv = int'($urandom_range(2**W - 1));
         bi = int'($urandom_range(1));
         run_op(W'(av), W'(bv), 1'(bi), gd, gb, go, lat);
         total++;
         if ({gb, gd} !== ref_sub(av, bv, bi)) begin
            bad++;
            $display("FAIL random a=%0d b=%0d bin=%0d: bout,diff=%h required=%h", av, bv, bi, {gb, gd}, ref_sub(av, bv, bi));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_ignore_busy();
      test_reset_mid();
      test_ovf();
      test_sweep();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
